emu_host_sequencer: RTL and testbench

Host-side command sequencer for the co-emulation chip-test flow. It sits directly upstream of the per-design chip-test wrapper and drives that wrapper's emulation port (Din_emu, Addr_emu, load_emu, get_emu, clk_dut). It consumes Dout_emu from the same port. It turns a byte stream from the host link (UART/FIFO bridge) into stimulus writes, load strobes, controlled DUT clock pulses, capture strobes and read-back bytes returned to the host.

---
 rtl/emu_seq_pkg.sv | 28 ++
 rtl/emu_clk_pulse.sv | 57 +++++
 rtl/emu_host_sequencer.sv | 167 ++++++++++++++++
 tb/tb_emu_host_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/emu_seq_pkg.sv
// Shared opcodes, response bytes and sequencer states for the host-side
// co-emulation command sequencer.
package emu_seq_pkg;

  localparam logic [7:0] OP_PING  = 8'h00;
  localparam logic [7:0] OP_STEP  = 8'h01;
  localparam logic [7:0] OP_CLOCK = 8'h02;

  localparam logic [7:0] RSP_PING = 8'hA5;
  localparam logic [7:0] RSP_CLK  = 8'hC0;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  // S_PULSE covers both the high and low phases; the pulse generator tracks them.
  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_STIM,
    S_SETTLE,
    S_LOAD,
    S_PULSE,
    S_GET,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_CAP,
    S_TX,
    S_RX_CNT
  } state_t;

endpackage

// File: rtl/emu_clk_pulse.sv
// Controlled DUT clock: after a start request, emits i_count pulses of
// i_half cycles high / i_half cycles low; o_done marks the final low cycle.
module emu_clk_pulse (
  input  logic       clk_emu,
  input  logic       reset,
  input  logic       i_start,
  input  logic [8:0] i_count,
  input  logic [7:0] i_half,
  output logic       o_clk,
  output logic       o_done
);

  logic       r_arm;
  logic       r_run;
  logic       r_clk;
  logic [7:0] r_half;
  logic [8:0] r_cnt;

  // One arm cycle between start and the first rising edge keeps clk_dut
  // clear of the load strobe issued alongside start.
  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      r_arm  <= 1'b0;
      r_run  <= 1'b0;
      r_clk  <= 1'b0;
      r_half <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_arm <= 1'b1;
      r_run <= 1'b0;
      r_clk <= 1'b0;
      r_cnt <= i_count;
    end else if (r_arm) begin
      r_arm  <= 1'b0;
      r_run  <= 1'b1;
      r_clk  <= 1'b1;
      r_half <= i_half - 8'd1;
    end else if (r_run) begin
      if (r_half != 8'd0) begin
        r_half <= r_half - 8'd1;
      end else if (r_clk) begin
        r_clk  <= 1'b0;
        r_half <= i_half - 8'd1;
      end else if (r_cnt == 9'd1) begin
        r_run <= 1'b0;
      end else begin
        r_cnt  <= r_cnt - 9'd1;
        r_clk  <= 1'b1;
        r_half <= i_half - 8'd1;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_done = r_run && !r_clk && (r_half == 8'd0) && (r_cnt == 9'd1);

endmodule

// File: rtl/emu_host_sequencer.sv
// Host-link command sequencer driving the chip-test wrapper emulation port:
// PING, STEP (stimulus write, load, one clock, capture, read-back) and CLOCK.
module emu_host_sequencer
  import emu_seq_pkg::*;
#(
  parameter int unsigned NUM_STIM = 2,
  parameter int unsigned NUM_OUT  = 2,
  parameter int unsigned CLK_HALF = 1
) (
  input  logic       clk_emu,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] Din_emu,
  output logic [2:0] Addr_emu,
  output logic       load_emu,
  output logic       get_emu,
  input  logic [7:0] Dout_emu,
  output logic       clk_dut,
  output logic       busy
);

  localparam logic [2:0] LAST_K = 3'(NUM_STIM - 1);
  localparam logic [2:0] LAST_J = 3'(NUM_OUT - 1);

  state_t     r_state, w_next;
  logic [2:0] r_k, r_j;
  logic       r_step;
  logic [7:0] r_tx_data, r_din;
  logic       r_tx_valid, r_load, r_get, r_busy;
  logic [2:0] r_addr;
  logic       w_start, w_done, w_clk;
  logic [8:0] w_count;

  assign w_start = (r_state == S_LOAD) || ((r_state == S_RX_CNT) && rx_valid);
  assign w_count = (r_state == S_LOAD) ? 9'd1 :
                   (rx_data == 8'h00)  ? 9'h100 : {1'b0, rx_data};

  emu_clk_pulse u_pulse (
    .clk_emu (clk_emu),
    .reset   (reset),
    .i_start (w_start),
    .i_count (w_count),
    .i_half  (CLK_HALF[7:0]),
    .o_clk   (w_clk),
    .o_done  (w_done)
  );

  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if      (rx_data == OP_STEP)  w_next = S_RX_STIM;
          else if (rx_data == OP_CLOCK) w_next = S_RX_CNT;
          else                          w_next = S_TX;
        end
      end
      S_RX_STIM: begin
        rx_ready = 1'b1;
        if (rx_valid && (r_k == LAST_K)) w_next = S_SETTLE;
      end
      S_SETTLE:  w_next = S_LOAD;
      S_LOAD:    w_next = S_PULSE;
      S_PULSE:   if (w_done) w_next = r_step ? S_GET : S_TX;
      S_GET:     w_next = S_RD_ADDR;
      S_RD_ADDR: w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_RD_CAP;
      S_RD_CAP:  w_next = S_TX;
      S_TX: begin
        if (tx_ready) w_next = (r_step && (r_j != LAST_J)) ? S_RD_ADDR : S_IDLE;
      end
      S_RX_CNT: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = S_PULSE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // load_emu trails the LOAD state by a cycle; get_emu coincides with GET.
  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      r_k        <= '0;
      r_j        <= '0;
      r_step     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_din      <= '0;
      r_addr     <= '0;
      r_load     <= 1'b0;
      r_get      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_load <= (r_state == S_LOAD);
      r_get  <= (w_next == S_GET);
      r_busy <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_k    <= '0;
            r_step <= (rx_data == OP_STEP);
            if (rx_data == OP_PING) begin
              r_tx_data  <= RSP_PING;
              r_tx_valid <= 1'b1;
            end else if ((rx_data != OP_STEP) && (rx_data != OP_CLOCK)) begin
              r_tx_data  <= RSP_ERR;
              r_tx_valid <= 1'b1;
            end
          end
        end
        S_RX_STIM: begin
          if (rx_valid) begin
            r_addr <= r_k;
            r_din  <= rx_data;
            r_k    <= r_k + 3'd1;
          end
        end
        S_PULSE: begin
          if (w_done && !r_step) begin
            r_tx_data  <= RSP_CLK;
            r_tx_valid <= 1'b1;
          end
        end
        S_GET: begin
          r_addr <= '0;
          r_j    <= '0;
        end
        S_RD_CAP: begin
          r_tx_data  <= Dout_emu;
          r_tx_valid <= 1'b1;
        end
        S_TX: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_step && (r_j != LAST_J)) begin
              r_j    <= r_j + 3'd1;
              r_addr <= r_j + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign Din_emu  = r_din;
  assign Addr_emu = r_addr;
  assign load_emu = r_load;
  assign get_emu  = r_get;
  assign clk_dut  = w_clk;
  assign busy     = r_busy;

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Scoreboard bench: commands push expected tx bytes, a monitor pops and compares
// them, and a behavioural wrapper/DUT (out0 = in0 + 1, out1 = in1 ^ 0x5A) closes the loop.
module tb_emu_host_sequencer;
  import emu_seq_pkg::*;

  localparam int unsigned HALF = 2;

  logic       clk_emu = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic       rx_ready, tx_valid, load_emu, get_emu, clk_dut, busy;
  logic [7:0] tx_data, Din_emu;
  logic [7:0] Dout_emu = 8'h00;
  logic [2:0] Addr_emu;

  always #5 clk_emu = ~clk_emu;

  emu_host_sequencer #(.NUM_STIM(2), .NUM_OUT(2), .CLK_HALF(HALF)) dut (
    .clk_emu(clk_emu), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .Din_emu(Din_emu), .Addr_emu(Addr_emu), .load_emu(load_emu), .get_emu(get_emu),
    .Dout_emu(Dout_emu), .clk_dut(clk_dut), .busy(busy)
  );

  logic [7:0] stim_mem [8] = '{default: 8'h00};
  logic [7:0] dut_in   [8] = '{default: 8'h00};
  logic [7:0] dut_out  [8] = '{default: 8'h00};
  logic [7:0] cap      [8] = '{default: 8'h00};

  always @(posedge clk_emu) begin
    stim_mem[Addr_emu] <= Din_emu;
    if (get_emu) for (int i = 0; i < 8; i++) cap[i] <= dut_out[i];
    Dout_emu <= cap[Addr_emu];
  end
  // Load is taken mid-cycle so the model has no same-edge ordering against clk_dut.
  always @(negedge clk_emu) if (load_emu) for (int i = 0; i < 8; i++) dut_in[i] <= stim_mem[i];
  always @(posedge clk_dut) begin
    dut_out[0] <= dut_in[0] + 8'd1;
    dut_out[1] <= dut_in[1] ^ 8'h5A;
  end

  int unsigned n_checks = 0, n_fail = 0;
  logic [7:0]  exp_q [$];
  int unsigned cyc = 0, n_rise = 0, n_load = 0, n_get = 0, n_viol = 0, n_tx = 0;
  int unsigned t_rise = 0, t_fall = 0, t_load = 0, t_get = 0, t_txv = 0;
  logic        prev_clk = 1'b0, prev_txv = 1'b0, txv_armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_emu);
      cyc++;
      if (clk_dut && !prev_clk) begin n_rise++; t_rise = cyc; txv_armed = 1'b1; end
      if (!clk_dut && prev_clk) t_fall = cyc;
      prev_clk = clk_dut;
      if (load_emu) begin n_load++; t_load = cyc; end
      if (get_emu)  begin n_get++;  t_get  = cyc; end
      if (tx_valid && !prev_txv && txv_armed) begin t_txv = cyc; txv_armed = 1'b0; end
      prev_txv = tx_valid;
      if ((load_emu && get_emu) || ((load_emu || get_emu) && clk_dut)) n_viol++;
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (exp_q.size() == 0) chk("tx_unexpected", 32'(exp_q.size()), 32'd1);
        else                   chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic        acc;
    int unsigned guard;
    acc = 1'b0;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && guard < 300) begin
      @(negedge clk_emu);
      acc = rx_ready;
      tick();
      guard++;
    end
    chk("rx_accept", 32'(acc), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned guard;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < budget) begin
      tick();
      guard++;
    end
    chk("idle_reached", 32'(busy || exp_q.size() != 0), 32'd0);
  endtask

  task automatic do_step(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0 + 8'd1);
    exp_q.push_back(b1 ^ 8'h5A);
    send_byte(OP_STEP);
    send_byte(b0);
    send_byte(b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b_rise, b_load, b_get, b_tx, guard;
    logic [7:0]  hold_d;
    logic [2:0]  hold_a;
    fork monitor(); join_none

    repeat (3) tick();
    @(negedge clk_emu);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_din", 32'(Din_emu), 32'd0);
    chk("rst_addr", 32'(Addr_emu), 32'd0);
    chk("rst_strobes", 32'({load_emu, get_emu, clk_dut}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    exp_q.push_back(RSP_PING);
    send_byte(OP_PING);
    wait_idle(50);

    exp_q.push_back(RSP_ERR);
    send_byte(8'h7F);
    exp_q.push_back(RSP_PING);
    send_byte(OP_PING);
    wait_idle(50);

    b_rise = n_rise; b_load = n_load; b_get = n_get; b_tx = n_tx;
    do_step(8'h05, 8'h3C);
    wait_idle(200);
    chk("step_loads", n_load - b_load, 1);
    chk("step_pulses", n_rise - b_rise, 1);
    chk("step_gets", n_get - b_get, 1);
    chk("step_tx_count", n_tx - b_tx, 2);
    chk("load_to_clk", t_rise - t_load, 1);
    chk("clk_high", t_fall - t_rise, HALF);
    chk("clk_low_to_get", t_get - t_fall, HALF);
    chk("first_tx_latency", t_txv - t_rise, 2 * HALF + 4);

    for (int i = 0; i < 3; i++) begin
      do_step(8'($urandom), 8'($urandom));
      wait_idle(200);
    end
    do_step(8'hFF, 8'h00);
    wait_idle(200);

    tx_ready = 1'b0;
    do_step(8'h41, 8'h99);
    guard = 0;
    while (!tx_valid && guard < 100) begin tick(); guard++; end
    chk("bp_tx_valid_seen", 32'(tx_valid), 32'd1);
    hold_d = tx_data;
    hold_a = Addr_emu;
    exp_q.push_back(RSP_PING);
    rx_data  = OP_PING;
    rx_valid = 1'b1;
    repeat (20) begin
      @(negedge clk_emu);
      chk("bp_tx_data", 32'(tx_data), 32'(hold_d));
      chk("bp_tx_valid", 32'(tx_valid), 32'd1);
      chk("bp_rx_ready", 32'(rx_ready), 32'd0);
      chk("bp_addr", 32'(Addr_emu), 32'(hold_a));
    end
    tick();
    tx_ready = 1'b1;
    send_byte(OP_PING);
    wait_idle(200);

    b_rise = n_rise; b_load = n_load; b_get = n_get;
    exp_q.push_back(RSP_CLK);
    send_byte(OP_CLOCK);
    send_byte(8'h00);
    wait_idle(3000);
    chk("clk256_pulses", n_rise - b_rise, 256);
    chk("clk256_strobes", (n_load - b_load) + (n_get - b_get), 0);

    b_rise = n_rise;
    exp_q.push_back(RSP_CLK);
    send_byte(OP_CLOCK);
    send_byte(8'h03);
    wait_idle(200);
    chk("clk3_pulses", n_rise - b_rise, 3);

    b_rise = n_rise; b_tx = n_tx;
    send_byte(OP_CLOCK);
    send_byte(8'hFF);
    guard = 0;
    while ((n_rise - b_rise) < 10 && guard < 200) begin @(negedge clk_emu); guard++; end
    chk("mid_clock_high", 32'(clk_dut), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_clk_dut", 32'(clk_dut), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_mid_no_tx", n_tx - b_tx, 0);
    exp_q.push_back(RSP_PING);
    send_byte(OP_PING);
    wait_idle(50);

    chk("strobe_overlap", n_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
